// File: rtl/cache_pkg.sv
// cache_pkg: shared sizes, state encoding and index types for the cache refill path.
package cache_pkg;
  localparam int WAY_NUM    = 4;
  localparam int INDEX_W    = 10;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = 128 / BEAT_W;
  localparam int DOMAIN_NUM = 2;
  localparam int DOM_W      = $clog2(DOMAIN_NUM);
  localparam int WAY_W      = $clog2(WAY_NUM);
  localparam int TAG_W      = 32 - INDEX_W - 4;
  typedef logic [WAY_W-1:0] way_idx_t;
  typedef logic [DOM_W-1:0] dom_t;
  typedef logic [127:0] cache_data_type;
  typedef enum logic [2:0] {IDLE, SELECT, WB_REQ, FILL_REQ, FILL, COMMIT} refill_state_e;
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the lowest invalid allowed way, else the next allowed way after a round-robin pointer.
// With DAWG_PARTITION_EN each domain owns a pointer; otherwise a single pointer is shared by all domains.
module cache_victim_sel
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WAY_NUM-1:0] valid,
  input  logic [WAY_NUM-1:0] allowed,
  input  dom_t               domain,
  input  logic               advance,
  output way_idx_t           victim,
  output logic               none
);
  way_idx_t [DOMAIN_NUM-1:0] rr_q, rr_d;
  way_idx_t inv_way, rr_way, cand;
  logic inv_hit;
  dom_t sel;
`ifdef DAWG_PARTITION_EN
  assign sel = domain;
`else
  logic unused_dom;
  assign sel = '0;
  assign unused_dom = ^domain;
`endif
  always_comb begin
    inv_hit = 1'b0;
    inv_way = '0;
    rr_way = rr_q[sel];
    cand = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (allowed[i] && !valid[i]) begin
        inv_hit = 1'b1;
        inv_way = way_idx_t'(i);
      end
    end
    // Offset WAY_NUM wraps to the pointer itself, so a lone allowed way is still found.
    for (int i = WAY_NUM; i >= 1; i--) begin
      cand = rr_q[sel] + way_idx_t'(i);
      if (allowed[cand]) rr_way = cand;
    end
  end
  assign none = ~|allowed;
  assign victim = inv_hit ? inv_way : rr_way;
  always_comb begin
    rr_d = rr_q;
    if (advance && !inv_hit && !none) rr_d[sel] = rr_way;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else rr_q <= rr_d;
  end
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler -- victim pick, dirty writeback in beats, line fill, one-cycle array write.
// Define DAWG_PARTITION_EN to restrict victims to the requesting domain's cfg_way_mask ways.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [31:0]                   miss_addr,
  input  logic [DOM_W-1:0]              miss_domain,
  input  logic [WAY_NUM-1:0]            set_valid,
  input  logic [WAY_NUM-1:0]            set_dirty,
  input  logic [TAG_W-1:0]              victim_tag,
  input  logic [127:0]                  victim_line,
  input  logic [DOMAIN_NUM*WAY_NUM-1:0] cfg_way_mask,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [31:0]                   mem_req_addr,
  output logic [BEAT_W-1:0]             mem_wdata,
  input  logic                          mem_rvalid,
  input  logic [BEAT_W-1:0]             mem_rdata,
  output logic                          data_we,
  output logic [INDEX_W-1:0]            data_index,
  output logic [WAY_W-1:0]              data_way,
  output logic [127:0]                  data_wline,
  output logic                          done_valid,
  output logic                          done_err
);
  refill_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  dom_t dom_q, dom_d;
  logic [WAY_NUM-1:0] valid_q, valid_d, dirty_q, dirty_d, allowed;
  way_idx_t way_q, way_d, victim;
  logic [1:0] beat_q, beat_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  cache_data_type wb_q, wb_d, line_q, line_d;
  logic none, select;
`ifdef DAWG_PARTITION_EN
  assign allowed = cfg_way_mask[{dom_q, 2'b00} +: WAY_NUM];
`else
  logic unused_cfg;
  assign allowed = '1;
  assign unused_cfg = ^cfg_way_mask;
`endif
  assign select = state_q == SELECT;
  cache_victim_sel u_sel (
    .clk(clk),
    .rst(rst),
    .valid(valid_q),
    .allowed(allowed),
    .domain(dom_q),
    .advance(select),
    .victim(victim),
    .none(none)
  );
  assign data_index = addr_q[INDEX_W+3:4];
  assign data_way = way_q;
  assign data_wline = line_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    dom_d = dom_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    way_d = way_q;
    beat_d = beat_q;
    tag_d = tag_q;
    wb_d = wb_q;
    line_d = line_q;
    miss_ready = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we = 1'b0;
    mem_req_addr = addr_q;
    mem_wdata = wb_q[{beat_q, 5'd0} +: BEAT_W];
    data_we = 1'b0;
    done_valid = 1'b0;
    done_err = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          state_d = SELECT;
          addr_d = miss_addr;
          dom_d = miss_domain;
          valid_d = set_valid;
          dirty_d = set_dirty;
        end
      end
      SELECT: begin
        way_d = victim;
        beat_d = '0;
        wb_d = victim_line;
        tag_d = victim_tag;
        done_valid = none;
        done_err = none;
        state_d = none ? IDLE : (dirty_q[victim] ? WB_REQ : FILL_REQ);
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we = 1'b1;
        mem_req_addr = {tag_q, addr_q[INDEX_W+3:4], beat_q, 2'b00};
        if (mem_req_ready) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q) state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = FILL;
      end
      FILL: begin
        if (mem_rvalid) begin
          line_d[{beat_q, 5'd0} +: BEAT_W] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (&beat_q) state_d = COMMIT;
        end
      end
      COMMIT: begin
        data_we = 1'b1;
        done_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      dom_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      way_q <= '0;
      beat_q <= '0;
      tag_q <= '0;
      wb_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      dom_q <= dom_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      way_q <= way_d;
      beat_q <= beat_d;
      tag_q <= tag_d;
      wb_q <= wb_d;
      line_q <= line_d;
    end
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized miss traffic against a line-level reference model of the refill controller.
module tb_cache_refill_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic miss_valid = 1'b0, miss_ready;
  logic [31:0] miss_addr = '0;
  logic [0:0] miss_domain = '0;
  logic [3:0] set_valid = '0, set_dirty = '0;
  logic [17:0] victim_tag = '0;
  logic [127:0] victim_line = '0;
  logic [7:0] cfg_way_mask = '0;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
  logic [31:0] mem_req_addr, mem_wdata;
  logic mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic data_we;
  logic [9:0] data_index;
  logic [1:0] data_way;
  logic [127:0] data_wline;
  logic done_valid, done_err;

  int n_checks = 0, n_fail = 0;
  int rr[2];
  logic [31:0] wb_addr_q[$], wb_data_q[$];
  int n_fill, n_we, n_done, n_err, lat, fill_wb_cnt;
  logic [1:0] we_way;
  logic [9:0] we_index;
  logic [127:0] we_line;
  logic [31:0] fill_addr;
  logic timed_out, aborted, rst_ready;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_domain(miss_domain), .set_valid(set_valid), .set_dirty(set_dirty), .victim_tag(victim_tag),
    .victim_line(victim_line), .cfg_way_mask(cfg_way_mask), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .data_we(data_we),
    .data_index(data_index), .data_way(data_way), .data_wline(data_wline), .done_valid(done_valid),
    .done_err(done_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] allowed_of(input int dom);
`ifdef DAWG_PARTITION_EN
    return cfg_way_mask[dom*4 +: 4];
`else
    return 4'hF;
`endif
  endfunction

  // Reference victim choice: first free permitted way, otherwise the next permitted way after the pointer.
  function automatic int pick(input logic [3:0] v, input logic [3:0] al, input int dom);
`ifdef DAWG_PARTITION_EN
    int p = dom;
`else
    int p = 0;
`endif
    for (int w = 0; w < 4; w++) if (al[w] && !v[w]) return w;
    for (int s = 1; s <= 4; s++) begin
      if (al[(rr[p] + s) % 4]) begin
        rr[p] = (rr[p] + s) % 4;
        return rr[p];
      end
    end
    return -1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] wb_addr_of(input logic [17:0] tag, input logic [31:0] a, input int k);
    return (32'(tag) << 14) | (32'(a[13:4]) << 4) | 32'(k * 4);
  endfunction

  task automatic do_miss(input logic [31:0] addr, input int dom, input logic [3:0] v, input logic [3:0] d,
                         input logic [17:0] tag, input logic [127:0] vline, input logic [127:0] fline,
                         input int max_wait, input int gap_pct, input int rst_beat);
    int wait_n, sent, cyc;
    bit fill_go, fill_act, fin;
    wb_addr_q.delete();
    wb_data_q.delete();
    n_fill = 0; n_we = 0; n_done = 0; n_err = 0; lat = -1; fill_wb_cnt = -1;
    timed_out = 1'b0; aborted = 1'b0; rst_ready = 1'b0;
    miss_valid = 1'b1; miss_addr = addr; miss_domain = 1'(dom); set_valid = v; set_dirty = d;
    victim_tag = tag; victim_line = vline;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    wait_n = max_wait; sent = 0; cyc = 1; fill_go = 0; fill_act = 0; fin = 0;
    while (!fin) begin
      if (cyc > 400) begin
        timed_out = 1'b1;
        break;
      end
      if (data_we) begin
        n_we++; we_way = data_way; we_index = data_index; we_line = data_wline;
        if (lat < 0) lat = cyc;
      end
      if (done_valid) begin
        n_done++;
        n_err += int'(done_err);
        fin = 1;
      end
      if (fill_go) begin
        fill_act = 1;
        fill_go = 0;
      end
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (mem_req_valid) begin
        if (wait_n > 0) wait_n--;
        else begin
          mem_req_ready = 1'b1;
          wait_n = max_wait;
          if (mem_req_we) begin
            wb_addr_q.push_back(mem_req_addr);
            wb_data_q.push_back(mem_wdata);
          end else begin
            n_fill++; fill_addr = mem_req_addr; fill_go = 1; fill_wb_cnt = wb_addr_q.size();
          end
        end
      end
      if (fill_act && sent < 4) begin
        if (sent == rst_beat) begin
          mem_rvalid = 1'b1; mem_rdata = fline[32*sent +: 32];
          rst = 1'b1; #1;
          rst_ready = miss_ready;
          if (data_we || done_valid) n_we++;
          @(posedge clk); #1;
          if (data_we || done_valid) n_we++;
          rst = 1'b0; aborted = 1'b1; mem_rvalid = 1'b0;
          @(posedge clk); #1;
          return;
        end
        if ($urandom_range(99) >= gap_pct) begin
          mem_rvalid = 1'b1; mem_rdata = fline[32*sent +: 32]; sent++;
        end
      end else if ($urandom_range(99) < 30) mem_rvalid = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    mem_req_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_miss_ready: got %b want 1", miss_ready); end
    n_checks++;
    if ({mem_req_valid, mem_req_we, data_we, done_valid, done_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {mem_req_valid, mem_req_we, data_we, done_valid, done_err});
    end
    rst = 1'b0;
    rr[0] = 0; rr[1] = 0;
    @(posedge clk); #1;
    n_checks++;
    if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", miss_ready); end
  endtask

  task automatic test_basic_fill();
    logic [127:0] fl = rand128();
    logic [31:0] a = $urandom() & 32'hFFFF_FFF0;
    int ew;
    cfg_way_mask = 8'b1100_0011;
    ew = pick(4'b0000, allowed_of(0), 0);
    do_miss(a, 0, 4'b0000, 4'b0000, 18'h0, '0, fl, 0, 0, -1);
    n_checks++;
    if (timed_out || n_done != 1 || n_err != 0) begin
      n_fail++; $display("FAIL basic_done: timeout=%b done=%0d err=%0d want 0/1/0", timed_out, n_done, n_err);
    end
    n_checks++;
    if (n_we != 1 || we_way !== 2'(ew) || ew != 0) begin
      n_fail++; $display("FAIL basic_way: we=%0d way=%0d want 1 write to way 0", n_we, we_way);
    end
    n_checks++;
    if (we_line !== fl) begin n_fail++; $display("FAIL basic_line: got %h want %h", we_line, fl); end
    n_checks++;
    if (we_index !== a[13:4]) begin n_fail++; $display("FAIL basic_index: got %h want %h", we_index, a[13:4]); end
    n_checks++;
    if (lat != 7) begin n_fail++; $display("FAIL basic_latency: got %0d want 7", lat); end
    n_checks++;
    if (wb_addr_q.size() != 0 || n_fill != 1 || fill_addr !== a) begin
      n_fail++; $display("FAIL basic_mem: wb=%0d fills=%0d addr=%h want 0/1/%h", wb_addr_q.size(), n_fill, fill_addr, a);
    end
    n_checks++;
    if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle: got %b want 1", miss_ready); end
  endtask

  task automatic test_rr_victims();
    logic [127:0] fl;
    int ew;
    cfg_way_mask = 8'b1100_0011;
    for (int k = 0; k < 3; k++) begin
      fl = rand128();
      ew = pick(4'hF, allowed_of(1), 1);
      do_miss($urandom() & 32'hFFFF_FFF0, 1, 4'hF, 4'h0, 18'($urandom()), rand128(), fl, 0, 20, -1);
      n_checks++;
      if (timed_out || n_we != 1 || we_way !== 2'(ew) || we_line !== fl || wb_addr_q.size() != 0) begin
        n_fail++;
        $display("FAIL rr_victim%0d: we=%0d way=%0d wb=%0d want 1 write way %0d no wb", k, n_we, we_way, wb_addr_q.size(), ew);
      end
`ifdef DAWG_PARTITION_EN
      n_checks++;
      if (we_way !== (k == 1 ? 2'd3 : 2'd2)) begin
        n_fail++; $display("FAIL rr_partition%0d: got way %0d want %0d", k, we_way, k == 1 ? 3 : 2);
      end
`endif
    end
  endtask

  task automatic test_dirty_wb();
    logic [127:0] fl = rand128(), vl = rand128();
    logic [17:0] tg = 18'($urandom());
    logic [31:0] a = $urandom() & 32'hFFFF_FFF0;
    int ew;
    cfg_way_mask = 8'b1100_0011;
    ew = pick(4'hF, allowed_of(0), 0);
    do_miss(a, 0, 4'hF, 4'hF, tg, vl, fl, 3, 0, -1);
    n_checks++;
    if (timed_out || wb_addr_q.size() != 4 || fill_wb_cnt != 4 || n_fill != 1) begin
      n_fail++; $display("FAIL wb_count: wb=%0d before_fill=%0d fills=%0d want 4/4/1", wb_addr_q.size(), fill_wb_cnt, n_fill);
    end
    for (int k = 0; k < wb_addr_q.size() && k < 4; k++) begin
      n_checks++;
      if (wb_addr_q[k] !== wb_addr_of(tg, a, k) || wb_data_q[k] !== vl[32*k +: 32]) begin
        n_fail++;
        $display("FAIL wb_beat%0d: addr=%h data=%h want %h/%h", k, wb_addr_q[k], wb_data_q[k], wb_addr_of(tg, a, k), vl[32*k +: 32]);
      end
    end
    n_checks++;
    if (n_we != 1 || we_way !== 2'(ew) || we_line !== fl) begin
      n_fail++; $display("FAIL wb_commit: we=%0d way=%0d line=%h want 1/%0d/%h", n_we, we_way, we_line, ew, fl);
    end
  endtask

  task automatic test_mask_zero();
    logic [127:0] fl = rand128();
    int ew;
    cfg_way_mask = 8'b0000_0011;
    ew = pick(4'b0101, allowed_of(1), 1);
    do_miss($urandom() & 32'hFFFF_FFF0, 1, 4'b0101, 4'b0000, 18'($urandom()), rand128(), fl, 0, 0, -1);
    n_checks++;
    if (timed_out || n_done != 1) begin n_fail++; $display("FAIL mask_done: timeout=%b done=%0d want 0/1", timed_out, n_done); end
    if (ew < 0) begin
      n_checks++;
      if (n_err != 1 || n_we != 0 || n_fill != 0 || wb_addr_q.size() != 0) begin
        n_fail++; $display("FAIL mask_err: err=%0d we=%0d fills=%0d wb=%0d want 1/0/0/0", n_err, n_we, n_fill, wb_addr_q.size());
      end
    end else begin
      n_checks++;
      if (n_err != 0 || n_we != 1 || we_way !== 2'(ew) || we_line !== fl) begin
        n_fail++; $display("FAIL mask_fill: err=%0d we=%0d way=%0d want 0/1/%0d", n_err, n_we, we_way, ew);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [127:0] fl = rand128();
    int ew;
    cfg_way_mask = 8'b1100_0011;
    do_miss($urandom() & 32'hFFFF_FFF0, 0, 4'h0, 4'h0, 18'h0, '0, fl, 0, 0, 2);
    rr[0] = 0; rr[1] = 0;
    n_checks++;
    if (!aborted || rst_ready !== 1'b1 || n_we != 0) begin
      n_fail++; $display("FAIL rst_mid: aborted=%b ready=%b writes=%0d want 1/1/0", aborted, rst_ready, n_we);
    end
    fl = rand128();
    ew = pick(4'b0011, allowed_of(0), 0);
    do_miss($urandom() & 32'hFFFF_FFF0, 0, 4'b0011, 4'h0, 18'h0, '0, fl, 1, 10, -1);
    n_checks++;
    if (timed_out || n_we != 1 || we_way !== 2'(ew) || we_line !== fl) begin
      n_fail++; $display("FAIL rst_recover: we=%0d way=%0d line=%h want 1/%0d/%h", n_we, we_way, we_line, ew, fl);
    end
  endtask

  task automatic test_random();
    logic [127:0] fl, vl;
    logic [31:0] a;
    logic [17:0] tg;
    logic [3:0] v, d;
    int dom, ew, nwb;
    for (int it = 0; it < 40; it++) begin
      cfg_way_mask = ($urandom_range(7) == 0) ? 8'($urandom() & 32'h0F) : 8'($urandom());
      fl = rand128(); vl = rand128(); tg = 18'($urandom()); a = $urandom() & 32'hFFFF_FFF0;
      v = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom()); d = 4'($urandom());
      dom = $urandom_range(1);
      ew = pick(v, allowed_of(dom), dom);
      do_miss(a, dom, v, d, tg, vl, fl, $urandom_range(2), 30, -1);
      nwb = (ew >= 0 && d[ew]) ? 4 : 0;
      n_checks++;
      if (timed_out || n_done != 1 || n_err != (ew < 0 ? 1 : 0) || n_we != (ew < 0 ? 0 : 1)) begin
        n_fail++; $display("FAIL rand%0d_done: timeout=%b done=%0d err=%0d we=%0d expected way %0d", it, timed_out, n_done, n_err, n_we, ew);
      end
      n_checks++;
      if (wb_addr_q.size() != nwb || n_fill != (ew < 0 ? 0 : 1)) begin
        n_fail++; $display("FAIL rand%0d_mem: wb=%0d fills=%0d want %0d/%0d", it, wb_addr_q.size(), n_fill, nwb, ew < 0 ? 0 : 1);
      end
      for (int k = 0; k < wb_addr_q.size() && k < nwb; k++) begin
        n_checks++;
        if (wb_addr_q[k] !== wb_addr_of(tg, a, k) || wb_data_q[k] !== vl[32*k +: 32]) begin
          n_fail++; $display("FAIL rand%0d_wb%0d: addr=%h data=%h want %h/%h", it, k, wb_addr_q[k], wb_data_q[k], wb_addr_of(tg, a, k), vl[32*k +: 32]);
        end
      end
      if (ew >= 0) begin
        n_checks++;
        if (we_way !== 2'(ew) || we_line !== fl || we_index !== a[13:4] || fill_addr !== a) begin
          n_fail++; $display("FAIL rand%0d_commit: way=%0d idx=%h line=%h want %0d/%h/%h", it, we_way, we_index, we_line, ew, a[13:4], fl);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_rr_victims();
    test_dirty_wb();
    test_mask_zero();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
